id_hazard_controller: RTL

- Pipeline sequencing controller for the ID stage of the 5-stage MIPS core.
- Keeps a 3-entry scoreboard of in-flight destination registers for the EX, MEM and WB slots.
- Detects load-use hazards and stalls IF/ID while injecting a bubble into ID/EX.
- Generates registered forwarding selects for the instruction entering EX, and squashes younger instructions when a branch resolves taken in MEM.

---
 rtl/id_hazard_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/id_hazard_controller.sv
// -----------------------------------------------------------------------------
// id_hazard_controller
//
// ID-stage sequencing controller for a 5-stage MIPS pipeline. It tracks the
// destination registers of the instructions in the EX, MEM and WB slots and
// uses them to:
//   - stall IF/ID and inject an ID/EX bubble on a load-use hazard,
//   - produce registered ALU forwarding selects for the instruction entering EX,
//   - flush the three younger pipeline registers when a branch in MEM is taken.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      source register specifiers of the ID instruction
//   id_uses_rt        ID instruction reads rt as a source
//   id_dest           destination after the RegDst mux
//   id_reg_write      RegWrite of the ID instruction
//   id_mem_read       MemRead of the ID instruction (load)
//   branch_taken      branch in MEM resolved taken this cycle
//   stall             hold PC and IF/ID, zero the ID/EX controls
//   flush_if_id       clear IF/ID at the next edge
//   flush_id_ex       clear ID/EX at the next edge
//   flush_ex_mem      clear EX/MEM at the next edge
//   fwd_a, fwd_b      ALU operand sources for the instruction in EX
//                     (00 regfile, 01 EX/MEM result, 10 MEM/WB data)
//   stall_count       saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module id_hazard_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_count
);

    // One scoreboard entry: valid, destination, RegWrite, MemRead.
    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dest;
        logic                  rw;
        logic                  mr;
    } slot_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    slot_t             ex_q,  ex_d;
    slot_t             mem_q, mem_d;
    slot_t             wb_q,  wb_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic rs_hit_ex, rs_hit_mem, rt_hit_ex, rt_hit_mem;
    logic load_use;
    logic issue;

    // $zero is hard-wired, so a write to it never creates a dependency.
    function automatic logic hit(input logic [REG_ADDR_W-1:0] x, input slot_t s);
        return s.v & s.rw & (s.dest != '0) & (s.dest == x);
    endfunction

    // The newest producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] fwd_sel(input logic h_ex, input logic h_mem);
        if (h_ex)       return FWD_EX;
        else if (h_mem) return FWD_MEM;
        else            return FWD_RF;
    endfunction

    // The WB slot is never consulted for forwarding: the register file writes
    // in the first half-cycle, so ID already reads the WB value directly.
    logic wb_unused;
    assign wb_unused = ^wb_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ex_d    = '0;
        mem_d   = ex_q;
        wb_d    = mem_q;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        cnt_d   = cnt_q;

        rs_hit_ex  = hit(id_rs, ex_q);
        rs_hit_mem = hit(id_rs, mem_q);
        rt_hit_ex  = hit(id_rt, ex_q);
        rt_hit_mem = hit(id_rt, mem_q);

        // A load in EX has no data until the end of MEM; the consumer waits
        // one cycle and then picks the value up from MEM/WB.
        load_use = id_valid & ex_q.mr & (rs_hit_ex | (id_uses_rt & rt_hit_ex));
        issue    = id_valid & ~load_use & ~branch_taken;

        // The instruction in EX is younger than the taken branch in MEM.
        if (branch_taken) begin
            mem_d.v = 1'b0;
        end

        if (issue) begin
            ex_d.v    = 1'b1;
            ex_d.dest = id_dest;
            ex_d.rw   = id_reg_write;
            ex_d.mr   = id_mem_read;
            fwd_a_d   = fwd_sel(rs_hit_ex, rs_hit_mem);
            // rt is forwarded even when unused; ALUSrc drops it downstream.
            fwd_b_d   = fwd_sel(rt_hit_ex, rt_hit_mem);
        end

        if (load_use && !branch_taken && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others (WB <= MEM <= EX shifts correctly).
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign stall        = rst_n & load_use & ~branch_taken;
    assign flush_if_id  = rst_n & branch_taken;
    assign flush_id_ex  = rst_n & branch_taken;
    assign flush_ex_mem = rst_n & branch_taken;
    assign fwd_a        = fwd_a_q;
    assign fwd_b        = fwd_b_q;
    assign stall_count  = cnt_q;

endmodule
